// File: rtl/buffer_reader.sv
// Capture-buffer readout engine: walks the last n samples of the
// circular RAM and hands them one at a time to the Tx protocol.
module buffer_reader #(
  parameter int BITS_ADC       = 8,
  parameter int RAM_ADDR_WIDTH = 12
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rqst_data,
  input  logic                      stop,
  input  logic                      capture_done,
  input  logic [RAM_ADDR_WIDTH-1:0] wr_ptr,
  input  logic [15:0]               num_samples,
  output logic [RAM_ADDR_WIDTH-1:0] rd_addr,
  output logic                      rd_en,
  input  logic [BITS_ADC-1:0]       rd_data,
  output logic [7:0]                tx_data,
  output logic                      tx_rdy,
  output logic                      tx_eof,
  input  logic                      tx_ack,
  output logic                      busy
);

  localparam int AW = RAM_ADDR_WIDTH;
  localparam int CW = RAM_ADDR_WIDTH + 1;
  localparam logic [31:0] DEPTH = 32'(1) << AW;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WAIT,
    SEND
  } state_t;

  state_t          state;
  logic [AW-1:0]   addr;
  logic [CW-1:0]   remaining;
  logic [CW-1:0]   n_clamp;
  logic [AW-1:0]   start_addr;
  logic [7:0]      samp8;
  logic [31:0]     ns_w;
  logic            start_ok;
  logic            last;

  // Clamp the request to the buffer depth and find the oldest sample.
  always_comb begin
    ns_w       = 32'(num_samples);
    n_clamp    = (ns_w > DEPTH) ? CW'(DEPTH) : CW'(ns_w);
    start_addr = wr_ptr - n_clamp[AW-1:0];
    start_ok   = rqst_data && capture_done &&
                 (n_clamp != '0) && !stop;
    last       = (remaining == CW'(1));
  end

  if (BITS_ADC >= 8) begin : g_trunc
    assign samp8 = rd_data[7:0];
  end else begin : g_ext
    assign samp8 = {{(8-BITS_ADC){1'b0}}, rd_data};
  end

  // Readout FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      addr      <= '0;
      remaining <= '0;
      rd_addr   <= '0;
      rd_en     <= 1'b0;
      tx_data   <= '0;
      tx_rdy    <= 1'b0;
      tx_eof    <= 1'b0;
      busy      <= 1'b0;
    end else if (stop) begin
      state  <= IDLE;
      rd_en  <= 1'b0;
      tx_rdy <= 1'b0;
      tx_eof <= 1'b0;
      busy   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start_ok) begin
            addr      <= start_addr;
            remaining <= n_clamp;
            rd_addr   <= start_addr;
            rd_en     <= 1'b1;
            busy      <= 1'b1;
            state     <= READ;
          end
        end
        READ: begin
          rd_en <= 1'b0;
          state <= WAIT;
        end
        WAIT: begin
          tx_data <= samp8;
          tx_rdy  <= 1'b1;
          tx_eof  <= last;
          state   <= SEND;
        end
        SEND: begin
          if (tx_ack) begin
            tx_rdy <= 1'b0;
            tx_eof <= 1'b0;
            if (last) begin
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              addr      <= addr + AW'(1);
              rd_addr   <= addr + AW'(1);
              remaining <= remaining - CW'(1);
              rd_en     <= 1'b1;
              state     <= READ;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_buffer_reader.sv
// Self-checking bench for buffer_reader with a 16-entry RAM
// holding RAM[i] = i + 0x10.
module tb_buffer_reader;

  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          rqst_data = 1'b0;
  logic          stop = 1'b0;
  logic          capture_done = 1'b0;
  logic [AW-1:0] wr_ptr = '0;
  logic [15:0]   num_samples = '0;
  logic [AW-1:0] rd_addr;
  logic          rd_en;
  logic [7:0]    rd_data = '0;
  logic [7:0]    tx_data;
  logic          tx_rdy;
  logic          tx_eof;
  logic          tx_ack = 1'b0;
  logic          busy;

  int checks = 0;
  int failures = 0;

  buffer_reader #(
    .BITS_ADC(8),
    .RAM_ADDR_WIDTH(AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rqst_data(rqst_data),
    .stop(stop),
    .capture_done(capture_done),
    .wr_ptr(wr_ptr),
    .num_samples(num_samples),
    .rd_addr(rd_addr),
    .rd_en(rd_en),
    .rd_data(rd_data),
    .tx_data(tx_data),
    .tx_rdy(tx_rdy),
    .tx_eof(tx_eof),
    .tx_ack(tx_ack),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rd_en) rd_data <= {4'h1, rd_addr};
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0] addr;
    logic [7:0] data;
    logic       eof;
  } smp_t;

  smp_t q[$];
  bit   active = 0;
  int   since = 0;

  // Model: expected sample list plus cycles since the last launch.
  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        active = 0;
        since = 0;
        q.delete();
      end else if (stop) begin
        active = 0;
        since = 0;
        q.delete();
      end else if (active && since >= 3 && tx_ack) begin
        void'(q.pop_front());
        if (q.size() == 0) begin
          active = 0;
          since = 0;
        end else begin
          since = 1;
        end
      end else if (!active && rqst_data && capture_done &&
                   num_samples != 0) begin
        int n;
        n = (num_samples > 16) ? 16 : int'(num_samples);
        for (int i = 0; i < n; i++) begin
          smp_t s;
          int a;
          a = ((int'(wr_ptr) - n + i) % 16 + 16) % 16;
          s.addr = 4'(a);
          s.data = 8'(a + 16);
          s.eof = (i == n - 1);
          q.push_back(s);
        end
        active = 1;
        since = 1;
      end else if (since > 0 && since < 3) begin
        since++;
      end
    end
  end

  // Compare DUT outputs with the model every cycle.
  initial begin
    forever begin
      @(negedge clk);
      chk("rd_en", 32'(rd_en), 32'(active && since == 1));
      chk("tx_rdy", 32'(tx_rdy), 32'(active && since >= 3));
      chk("busy", 32'(busy), 32'(active));
      if (active && since == 1 && q.size() > 0)
        chk("rd_addr", 32'(rd_addr), 32'(q[0].addr));
      if (active && since >= 3 && q.size() > 0) begin
        chk("tx_data", 32'(tx_data), 32'(q[0].data));
        chk("tx_eof", 32'(tx_eof), 32'(q[0].eof));
      end
    end
  end

  logic [7:0] dlog[$];
  logic       elog[$];
  logic [3:0] alog[$];
  int         rdcnt = 0;
  int         rdycnt = 0;

  // Record handshakes and read strobes for literal checks.
  initial begin
    forever begin
      @(posedge clk);
      if (rst && tx_rdy && tx_ack && !stop) begin
        dlog.push_back(tx_data);
        elog.push_back(tx_eof);
      end
      if (rst && rd_en) begin
        alog.push_back(rd_addr);
        rdcnt++;
      end
      if (rst && tx_rdy) rdycnt++;
    end
  end

  task automatic clear_logs();
    dlog.delete();
    elog.delete();
    alog.delete();
    rdcnt = 0;
    rdycnt = 0;
  endtask

  task automatic pulse_rqst();
    @(posedge clk);
    #1 rqst_data = 1'b1;
    @(posedge clk);
    #1 rqst_data = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    bit done;
    done = 0;
    for (int i = 0; i < budget; i++) begin
      if (!busy) begin
        done = 1;
        break;
      end
      @(posedge clk);
      #1;
    end
    chk("idle_timeout", 32'(done), 32'(1));
  endtask

  task automatic wait_rdy();
    bit done;
    done = 0;
    for (int i = 0; i < 20; i++) begin
      if (tx_rdy) begin
        done = 1;
        break;
      end
      @(posedge clk);
      #1;
    end
    chk("rdy_timeout", 32'(done), 32'(1));
  endtask

  task automatic ack_one();
    tx_ack = 1'b1;
    @(posedge clk);
    #1 tx_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  logic [7:0] wrap_d[6] = '{8'h1D, 8'h1E, 8'h1F, 8'h10, 8'h11, 8'h12};
  logic [3:0] wrap_a[6] = '{4'd13, 4'd14, 4'd15, 4'd0, 4'd1, 4'd2};
  logic [7:0] bp_d[4] = '{8'h14, 8'h15, 8'h16, 8'h17};
  logic [7:0] rs_d[3] = '{8'h1D, 8'h1E, 8'h1F};

  initial begin
    logic [7:0] held;
    #12;
    chk("rst_rd_addr", 32'(rd_addr), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_tx_eof", 32'(tx_eof), 0);
    chk("rst_busy", 32'(busy), 0);
    #20 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Wrap across the top of the buffer, ack tied high.
    clear_logs();
    capture_done = 1'b1;
    wr_ptr = 4'd3;
    num_samples = 16'd6;
    tx_ack = 1'b1;
    pulse_rqst();
    num_samples = 16'd2;
    wait_idle(100);
    tx_ack = 1'b0;
    chk("wrap_count", 32'(dlog.size()), 6);
    for (int i = 0; i < 6 && i < dlog.size(); i++) begin
      chk("wrap_data", 32'(dlog[i]), 32'(wrap_d[i]));
      chk("wrap_addr", 32'(alog[i]), 32'(wrap_a[i]));
      chk("wrap_eof", 32'(elog[i]), 32'(i == 5));
    end

    // Backpressure on the second sample; request while busy.
    clear_logs();
    wr_ptr = 4'd8;
    num_samples = 16'd4;
    pulse_rqst();
    for (int k = 1; k <= 4; k++) begin
      wait_rdy();
      if (k == 2) begin
        held = tx_data;
        for (int j = 0; j < 5; j++) begin
          @(posedge clk);
          #1;
          chk("bp_hold_rdy", 32'(tx_rdy), 1);
          chk("bp_hold_data", 32'(tx_data), 32'(held));
        end
      end
      ack_one();
      if (k == 1) begin
        rqst_data = 1'b1;
        @(posedge clk);
        #1 rqst_data = 1'b0;
      end
    end
    wait_idle(20);
    chk("bp_count", 32'(dlog.size()), 4);
    chk("bp_rd_en", 32'(rdcnt), 4);
    for (int i = 0; i < 4 && i < dlog.size(); i++)
      chk("bp_data", 32'(dlog[i]), 32'(bp_d[i]));

    // Clamp to the buffer depth.
    clear_logs();
    wr_ptr = 4'd5;
    num_samples = 16'd40;
    tx_ack = 1'b1;
    pulse_rqst();
    wait_idle(200);
    tx_ack = 1'b0;
    chk("clamp_count", 32'(dlog.size()), 16);
    if (dlog.size() > 0) begin
      chk("clamp_first_data", 32'(dlog[0]), 32'h15);
      chk("clamp_first_addr", 32'(alog[0]), 5);
    end

    // Ignored requests: zero length, no capture, stop priority.
    clear_logs();
    num_samples = 16'd0;
    pulse_rqst();
    repeat (6) @(posedge clk);
    capture_done = 1'b0;
    num_samples = 16'd5;
    pulse_rqst();
    repeat (6) @(posedge clk);
    capture_done = 1'b1;
    #1 stop = 1'b1;
    pulse_rqst();
    stop = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("ign_rd_en", 32'(rdcnt), 0);
    chk("ign_tx_rdy", 32'(rdycnt), 0);
    chk("ign_busy", 32'(busy), 0);

    // Abort together with the third ack, then restart.
    clear_logs();
    wr_ptr = 4'd10;
    num_samples = 16'd5;
    pulse_rqst();
    wait_rdy();
    ack_one();
    wait_rdy();
    ack_one();
    wait_rdy();
    tx_ack = 1'b1;
    stop = 1'b1;
    @(posedge clk);
    #1;
    tx_ack = 1'b0;
    stop = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_tx_rdy", 32'(tx_rdy), 0);
    chk("abort_tx_eof", 32'(tx_eof), 0);
    repeat (5) @(posedge clk);
    #1;
    chk("abort_rd_en", 32'(rdcnt), 3);
    chk("abort_count", 32'(dlog.size()), 2);
    clear_logs();
    tx_ack = 1'b1;
    pulse_rqst();
    wait_idle(50);
    tx_ack = 1'b0;
    chk("restart_count", 32'(dlog.size()), 5);
    if (alog.size() > 0)
      chk("restart_addr", 32'(alog[0]), 5);

    // Asynchronous reset during WAIT.
    clear_logs();
    wr_ptr = 4'd0;
    num_samples = 16'd3;
    tx_ack = 1'b1;
    pulse_rqst();
    chk("mid_rd_en", 32'(rd_en), 1);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("mid_busy", 32'(busy), 0);
    chk("mid_rd_en0", 32'(rd_en), 0);
    chk("mid_tx_rdy", 32'(tx_rdy), 0);
    chk("mid_tx_data", 32'(tx_data), 0);
    chk("mid_rd_addr", 32'(rd_addr), 0);
    #20 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    clear_logs();
    pulse_rqst();
    wait_idle(50);
    tx_ack = 1'b0;
    chk("rs_count", 32'(dlog.size()), 3);
    for (int i = 0; i < 3 && i < dlog.size(); i++)
      chk("rs_data", 32'(dlog[i]), 32'(rs_d[i]));

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
